// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the stream arbiter: default sizes, arbitration
// mode encodings and a constant-foldable ceil(log2) helper.
package stream_arbiter_pkg;

  localparam int DEFAULT_CHANNELS = 4;
  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_DEPTH    = 8;

  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;

  typedef enum logic [0:0] {
    ARB_RR   = 1'b0,
    ARB_PRIO = 1'b1
  } arb_mode_e;

  // Smallest r with (1 << r) >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO holding accepted words (data plus source channel).
// Push is refused when full and pop is refused when empty, so a caller
// can never corrupt the occupancy count. Pointers wrap naturally because
// DEPTH is a power of two.
module stream_fifo
  import stream_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int AW   = clog2(DEPTH);
  localparam int CNTW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_s, empty_s, push_ok_s, pop_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    full_s    = (count_q == CNTW'(DEPTH));
    empty_s   = (count_q == {CNTW{1'b0}});
    push_ok_s = push && !full_s;
    pop_ok_s  = pop && !empty_s;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNTW'(1'b1);
      2'b01:   count_d = count_q - CNTW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every stored word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNTW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_q;

endmodule

// File: rtl/stream_arbiter.sv
// N-to-1 stream arbiter feeding an output FIFO, with a sticky exception
// aggregator. Grant is combinational; a word moves only on stb && ack.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int MODE     = MODE_RR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*WIDTH-1:0]     input_in,
  input  logic [CHANNELS-1:0]           input_in_stb,
  output logic [CHANNELS-1:0]           input_in_ack,
  output logic [WIDTH-1:0]              output_out,
  output logic [clog2(CHANNELS)-1:0]    output_out_channel,
  output logic                          output_out_stb,
  input  logic                          output_out_ack,
  input  logic [CHANNELS-1:0]           exception_in,
  input  logic                          exception_clear,
  output logic                          exception,
  output logic [clog2(CHANNELS)-1:0]    exception_source
);

  localparam int        CHW      = clog2(CHANNELS);
  localparam int        FW       = WIDTH + CHW;
  localparam int        CNTW     = clog2(DEPTH + 1);
  localparam arb_mode_e ARB_MODE = (MODE == MODE_PRIO) ? ARB_PRIO : ARB_RR;

  logic [CHW-1:0]      last_granted_q, last_granted_d;
  logic                exception_q, exception_d;
  logic [CHW-1:0]      exception_source_q, exception_source_d;

  logic                grant_found_s;
  logic [CHW-1:0]      grant_idx_s;
  logic [CHANNELS-1:0] ack_s;
  logic                push_s;
  logic [WIDTH-1:0]    push_word_s;
  logic [FW-1:0]       fifo_rdata_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [CNTW-1:0]     fifo_count_s;
  logic                out_valid_s, pop_s;
  logic [CHW-1:0]      exc_low_idx_s;

  // Pick the winning channel: rotating search after the last grant, or lowest index.
  always_comb begin
    int             idx_v;
    logic [CHW-1:0] cand_v;
    grant_found_s = 1'b0;
    grant_idx_s   = {CHW{1'b0}};
    idx_v         = 0;
    cand_v        = {CHW{1'b0}};
    for (int off = 0; off < CHANNELS; off++) begin
      if (ARB_MODE == ARB_RR) begin
        idx_v = (int'(last_granted_q) + off + 1) % CHANNELS;
      end else begin
        idx_v = off;
      end
      cand_v = CHW'(idx_v);
      if (!grant_found_s && input_in_stb[cand_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_v;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accept only when the FIFO has room; a same-cycle pop never frees a full FIFO.
  always_comb begin
    ack_s       = {CHANNELS{1'b0}};
    push_s      = 1'b0;
    push_word_s = {WIDTH{1'b0}};
    if (grant_found_s && !fifo_full_s && !rst) begin
      ack_s[grant_idx_s] = 1'b1;
      push_s             = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (CHW'(c) == grant_idx_s) begin
        push_word_s = input_in[c*WIDTH +: WIDTH];
      end else begin
        push_word_s = push_word_s;
      end
    end
  end

  // Round-robin pointer advances only on a word actually taken.
  always_comb begin
    if (push_s && (ARB_MODE == ARB_RR)) begin
      last_granted_d = grant_idx_s;
    end else begin
      last_granted_d = last_granted_q;
    end
  end

  // Sticky exception: a new flag wins over clear; first source is latched.
  always_comb begin
    logic found_v;
    found_v       = 1'b0;
    exc_low_idx_s = {CHW{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (!found_v && exception_in[c]) begin
        found_v       = 1'b1;
        exc_low_idx_s = CHW'(c);
      end else begin
        found_v = found_v;
      end
    end
    if (|exception_in) begin
      exception_d = 1'b1;
      if (!exception_q) begin
        exception_source_d = exc_low_idx_s;
      end else begin
        exception_source_d = exception_source_q;
      end
    end else if (exception_clear) begin
      exception_d        = 1'b0;
      exception_source_d = {CHW{1'b0}};
    end else begin
      exception_d        = exception_q;
      exception_source_d = exception_source_q;
    end
  end

  // Control registers; reset points the rotation so channel 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_granted_q     <= CHW'(CHANNELS - 1);
      exception_q        <= 1'b0;
      exception_source_q <= {CHW{1'b0}};
    end else begin
      last_granted_q     <= last_granted_d;
      exception_q        <= exception_d;
      exception_source_q <= exception_source_d;
    end
  end

  stream_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({grant_idx_s, push_word_s}),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign out_valid_s        = (fifo_count_s != {CNTW{1'b0}}) && !rst;
  assign pop_s              = output_out_ack && !fifo_empty_s;
  assign input_in_ack       = ack_s;
  assign output_out_stb     = out_valid_s;
  assign output_out         = out_valid_s ? fifo_rdata_s[WIDTH-1:0] : {WIDTH{1'b0}};
  assign output_out_channel = out_valid_s ? fifo_rdata_s[FW-1:WIDTH] : {CHW{1'b0}};
  assign exception          = exception_q;
  assign exception_source   = exception_source_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus; a queue-based reference model predicts both.
module tb_stream_arbiter;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int D   = 8;

  typedef struct {
    logic [W-1:0] data;
    int           ch;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0]   in_stb = '0;
  logic             out_ack = 1'b0;
  logic [NCH-1:0]   exc_in = '0;
  logic             exc_clr = 1'b0;

  logic [NCH-1:0]   ack_o [2];
  logic [W-1:0]     out_o [2];
  logic [1:0]       ch_o  [2];
  logic             stb_o [2];
  logic             exc_o [2];
  logic [1:0]       src_o [2];

  always #5 clk = ~clk;

  stream_arbiter #(.CHANNELS(NCH), .WIDTH(W), .DEPTH(D), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .input_in(in_data), .input_in_stb(in_stb),
    .input_in_ack(ack_o[0]), .output_out(out_o[0]), .output_out_channel(ch_o[0]),
    .output_out_stb(stb_o[0]), .output_out_ack(out_ack), .exception_in(exc_in),
    .exception_clear(exc_clr), .exception(exc_o[0]), .exception_source(src_o[0])
  );

  stream_arbiter #(.CHANNELS(NCH), .WIDTH(W), .DEPTH(D), .MODE(1)) dut_pr (
    .clk(clk), .rst(rst), .input_in(in_data), .input_in_stb(in_stb),
    .input_in_ack(ack_o[1]), .output_out(out_o[1]), .output_out_channel(ch_o[1]),
    .output_out_stb(stb_o[1]), .output_out_ack(out_ack), .exception_in(exc_in),
    .exception_clear(exc_clr), .exception(exc_o[1]), .exception_source(src_o[1])
  );

  // Reference model state
  ent_t mq [2][$];
  int   last_g [2];
  logic m_exc;
  int   m_src;

  // Observations from the most recent cycle
  logic [NCH-1:0] obs_ack [2];
  logic [W-1:0]   obs_out [2];
  logic           obs_exc [2];
  logic [1:0]     obs_src [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int idx_of(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Expected accept vector for model m from current inputs and model state.
  function automatic logic [NCH-1:0] model_ack(input int m);
    int c;
    if (rst || mq[m].size() >= D) return '0;
    for (int k = 0; k < NCH; k++) begin
      c = (m == 0) ? (last_g[m] + 1 + k) % NCH : k;
      if (in_stb[c]) return NCH'(1 << c);
    end
    return '0;
  endfunction

  task automatic run_cycle();
    logic [NCH-1:0] ea [2];
    int c;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      ea[m]      = model_ack(m);
      obs_ack[m] = ack_o[m];
      obs_out[m] = out_o[m];
      obs_exc[m] = exc_o[m];
      obs_src[m] = src_o[m];
      chk($sformatf("ack m%0d", m), ack_o[m], ea[m]);
      chk($sformatf("stb m%0d", m), stb_o[m], (!rst && mq[m].size() > 0));
      if (!rst && mq[m].size() > 0) begin
        chk($sformatf("data m%0d", m), out_o[m], mq[m][0].data);
        chk($sformatf("chan m%0d", m), ch_o[m], mq[m][0].ch);
      end else if (rst) begin
        chk($sformatf("rst_data m%0d", m), out_o[m], 0);
        chk($sformatf("rst_chan m%0d", m), ch_o[m], 0);
      end
      chk($sformatf("exc m%0d", m), exc_o[m], rst ? 1'b0 : m_exc);
      chk($sformatf("src m%0d", m), src_o[m], rst ? 0 : m_src);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mq[m].delete();
        last_g[m] = NCH - 1;
      end else begin
        if (out_ack && mq[m].size() > 0) void'(mq[m].pop_front());
        if (ea[m] != 0) begin
          c = idx_of(ea[m]);
          mq[m].push_back('{data: in_data[c*W +: W], ch: c});
          if (m == 0) last_g[m] = c;
        end
      end
    end
    if (rst) begin
      m_exc = 1'b0;
      m_src = 0;
    end else if (exc_in != 0) begin
      if (!m_exc) m_src = idx_of(exc_in);
      m_exc = 1'b1;
    end else if (exc_clr) begin
      m_exc = 1'b0;
      m_src = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
    int w;
    int n_acc;
    last_g[0] = NCH - 1;
    last_g[1] = NCH - 1;
    m_exc = 1'b0;
    m_src = 0;

    // Reset state
    rst = 1'b1;
    run_cycle();
    run_cycle();
    rst = 1'b0;

    // Round-robin order with all channels requesting
    in_stb  = 4'hF;
    out_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      run_cycle();
      chk("rr_order", idx_of(obs_ack[0]), rr_exp[k]);
    end

    // Fixed priority holds the lower channel until it drops
    in_stb = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      run_cycle();
      chk("prio_hold", obs_ack[1], 4'b0010);
    end
    in_stb = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      run_cycle();
      chk("prio_next", obs_ack[1], 4'b1000);
    end

    // Fill to full with a blocked consumer, then pop-with-push-request
    do_reset();
    out_ack = 1'b0;
    in_stb  = 4'b0001;
    w = 1;
    n_acc = 0;
    for (int k = 0; k < 10; k++) begin
      in_data = '0;
      in_data[W-1:0] = w;
      run_cycle();
      if (obs_ack[0][0]) begin
        n_acc++;
        w++;
      end
    end
    chk("fill_count", n_acc, 8);
    chk("full_no_ack", obs_ack[0], 4'b0000);
    in_data[W-1:0] = w;
    out_ack = 1'b1;
    run_cycle();
    chk("full_pop_no_push", obs_ack[0], 4'b0000);
    out_ack = 1'b0;
    run_cycle();
    chk("refill_ack", obs_ack[0], 4'b0001);
    run_cycle();
    chk("full_again", obs_ack[0], 4'b0000);
    in_stb  = 4'b0000;
    out_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      chk("drain_order", obs_out[0], k + 2);
    end

    // Sticky exception capture, hold and clear
    exc_in = 4'b1010;
    run_cycle();
    exc_in = 4'b0000;
    run_cycle();
    chk("exc_set", obs_exc[0], 1'b1);
    chk("exc_src", obs_src[0], 2'd1);
    exc_in = 4'b0100;
    run_cycle();
    exc_in = 4'b0000;
    run_cycle();
    chk("exc_src_hold", obs_src[1], 2'd1);
    exc_clr = 1'b1;
    run_cycle();
    exc_clr = 1'b0;
    run_cycle();
    chk("exc_clr", obs_exc[0], 1'b0);
    chk("exc_clr_src", obs_src[0], 2'd0);

    // Reset with words queued
    do_reset();
    out_ack = 1'b0;
    in_stb  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      run_cycle();
    end
    rst = 1'b1;
    #1;
    chk("rst_async_stb", stb_o[0], 1'b0);
    chk("rst_async_ack", ack_o[0], 4'b0000);
    run_cycle();
    rst = 1'b0;
    run_cycle();
    chk("post_rst_grant", obs_ack[0], 4'b0001);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_stb  = NCH'($urandom);
      out_ack = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      exc_in  = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      exc_clr = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
